// File: rtl/operand_fwd_unit_pkg.sv
// Shared opcode, select-encoding and pipeline-slot definitions for operand forwarding.
package operand_fwd_unit_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_ITYPE  = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    // Forward selects are SEL_FWD_BASE + slot index, so slot k encodes as 1+k.
    localparam int SEL_REG      = 0;
    localparam int SEL_PC       = 1;
    localparam int SEL_IMM      = 1;
    localparam int SEL_FWD_BASE = 1;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    function automatic logic is_writer(input logic [6:0] op, input logic [4:0] rd);
        logic w;
        case (op)
            OP_RTYPE, OP_ITYPE, OP_LOAD, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w && (rd != 5'd0);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_STORE, OP_BRANCH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_imm_b(input logic [6:0] op);
        case (op)
            OP_ITYPE, OP_LOAD, OP_STORE, OP_JALR, OP_AUIPC, OP_LUI, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/operand_fwd_unit_if.sv
// X-stage instruction stream in, operand selects and hazard stall out.
interface operand_fwd_unit_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int SW = $clog2(DEPTH + 2);

    logic [XLEN-1:0] inst_X;
    logic            valid_X;
    logic            flush_X;
    logic            freeze;
    logic [SW-1:0]   sel_a;
    logic [SW-1:0]   sel_b;
    logic [SW-1:0]   sel_sd;
    logic            stall_req;
    logic [31:0]     stall_cnt;

    modport master (
        output inst_X, valid_X, flush_X, freeze,
        input  sel_a, sel_b, sel_sd, stall_req, stall_cnt
    );

    modport slave (
        input  inst_X, valid_X, flush_X, freeze,
        output sel_a, sel_b, sel_sd, stall_req, stall_cnt
    );
endinterface

// File: rtl/operand_fwd_unit_fwd_match.sv
// Priority match of one source register against the in-flight slots; youngest (lowest k) wins.
module fwd_match #(
    parameter int DEPTH = 2,
    parameter int IW    = $clog2(DEPTH + 1)
) (
    input  logic [4:0]         src,
    input  logic               used,
    input  logic [DEPTH-1:0]   slot_valid,
    input  logic [5*DEPTH-1:0] slot_rd,
    input  logic [DEPTH-1:0]   slot_load,
    output logic               hit,
    output logic [IW-1:0]      idx,
    output logic               is_load
);
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        // Scan oldest to youngest so the youngest match overwrites.
        for (int unsigned k = DEPTH; k >= 1; k--) begin
            if (used && (src != 5'd0) && slot_valid[k-1] && (slot_rd[5*(k-1) +: 5] == src)) begin
                hit     = 1'b1;
                idx     = IW'(k);
                is_load = slot_load[k-1];
            end
        end
    end
endmodule

// File: rtl/operand_fwd_unit.sv
// Operand forwarding / load-use hazard unit: tracks writers after X and steers operand muxes.
module operand_fwd_unit
    import operand_fwd_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 2,
    parameter int LOAD_RDY_STAGE = 1
) (
    input logic               clk,
    input logic               rst,
    operand_fwd_unit_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 2);
    localparam int IW = $clog2(DEPTH + 1);

    slot_t             slots [1:DEPTH];
    slot_t             new_slot;
    logic [31:0]       stall_cnt;
    logic              stall;

    logic [DEPTH-1:0]   slot_valid;
    logic [DEPTH-1:0]   slot_load;
    logic [5*DEPTH-1:0] slot_rd;

    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;
    logic       is_store;

    logic          hit_a, hit_b, hit_sd;
    logic          load_a, load_b, load_sd;
    logic [IW-1:0] idx_a, idx_b, idx_sd;

    assign opc      = bus.inst_X[6:0];
    assign rd       = bus.inst_X[11:7];
    assign rs1      = bus.inst_X[19:15];
    assign rs2      = bus.inst_X[24:20];
    assign is_store = (opc == OP_STORE);

    for (genvar g = 1; g <= DEPTH; g++) begin : g_flat
        assign slot_valid[g-1]     = slots[g].valid;
        assign slot_load[g-1]      = slots[g].is_load;
        assign slot_rd[5*(g-1) +: 5] = slots[g].rd;
    end

    fwd_match #(.DEPTH(DEPTH), .IW(IW)) u_match_a (
        .src(rs1), .used(uses_rs1(opc)),
        .slot_valid(slot_valid), .slot_rd(slot_rd), .slot_load(slot_load),
        .hit(hit_a), .idx(idx_a), .is_load(load_a)
    );

    fwd_match #(.DEPTH(DEPTH), .IW(IW)) u_match_b (
        .src(rs2), .used(uses_rs2(opc)),
        .slot_valid(slot_valid), .slot_rd(slot_rd), .slot_load(slot_load),
        .hit(hit_b), .idx(idx_b), .is_load(load_b)
    );

    fwd_match #(.DEPTH(DEPTH), .IW(IW)) u_match_sd (
        .src(rs2), .used(is_store),
        .slot_valid(slot_valid), .slot_rd(slot_rd), .slot_load(slot_load),
        .hit(hit_sd), .idx(idx_sd), .is_load(load_sd)
    );

    assign stall = bus.valid_X && !bus.flush_X &&
                   ((hit_a  && load_a  && (int'(idx_a)  < LOAD_RDY_STAGE)) ||
                    (hit_b  && load_b  && (int'(idx_b)  < LOAD_RDY_STAGE)) ||
                    (hit_sd && load_sd && (int'(idx_sd) < LOAD_RDY_STAGE)));

    always_comb begin
        bus.sel_a  = SW'(SEL_REG);
        bus.sel_b  = SW'(SEL_REG);
        bus.sel_sd = SW'(SEL_REG);
        if (opc == OP_AUIPC || opc == OP_JAL)
            bus.sel_a = SW'(SEL_PC);
        else if (hit_a)
            bus.sel_a = SW'(SEL_FWD_BASE) + SW'(idx_a);
        if (uses_imm_b(opc))
            bus.sel_b = SW'(SEL_IMM);
        else if (hit_b)
            bus.sel_b = SW'(SEL_FWD_BASE) + SW'(idx_b);
        if (hit_sd)
            bus.sel_sd = SW'(SEL_FWD_BASE) + SW'(idx_sd);
    end

    always_comb begin
        new_slot.valid   = bus.valid_X && !bus.flush_X && !stall && is_writer(opc, rd);
        new_slot.rd      = rd;
        new_slot.is_load = (opc == OP_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 1; k <= DEPTH; k++)
                slots[k] <= '0;
            stall_cnt <= '0;
        end else if (!bus.freeze) begin
            for (int unsigned k = DEPTH; k >= 2; k--)
                slots[k] <= slots[k-1];
            slots[1] <= new_slot;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_req = stall;
    assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_operand_fwd_unit.sv
// Directed bench: two configurations (DEPTH=2/LRS=1 and DEPTH=3/LRS=2) share one stimulus stream.
module tb_operand_fwd_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        valid, flush, freeze;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    operand_fwd_unit_if #(.XLEN(32), .DEPTH(2)) bus_a ();
    operand_fwd_unit_if #(.XLEN(32), .DEPTH(3)) bus_b ();

    assign bus_a.inst_X  = inst;
    assign bus_a.valid_X = valid;
    assign bus_a.flush_X = flush;
    assign bus_a.freeze  = freeze;
    assign bus_b.inst_X  = inst;
    assign bus_b.valid_X = valid;
    assign bus_b.flush_X = flush;
    assign bus_b.freeze  = freeze;

    operand_fwd_unit #(.XLEN(32), .DEPTH(2), .LOAD_RDY_STAGE(1)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    operand_fwd_unit #(.XLEN(32), .DEPTH(3), .LOAD_RDY_STAGE(2)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    function automatic logic [31:0] r_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd1, rs1, 3'd0, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, 5'd0, 7'b1100011};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; flush = 1'b0; freeze = 1'b0; inst = '0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Empty slots, plain RTYPE
        inst = r_op(5'd3, 5'd1, 5'd2); valid = 1'b1; settle();
        chk("rst_sel_a",  32'(bus_a.sel_a), 0);
        chk("rst_sel_b",  32'(bus_a.sel_b), 0);
        chk("rst_stall",  32'(bus_a.stall_req), 0);
        chk("rst_cnt",    bus_a.stall_cnt, 0);
        chk("rst_sel_sd", 32'(bus_a.sel_sd), 0);

        // Forward distance 1, 2 and (DEPTH=3 only) 3
        do_reset();
        inst = addi(5'd5, 5'd0); valid = 1'b1; settle();
        chk("addi_sel_a", 32'(bus_a.sel_a), 0);
        chk("addi_sel_b", 32'(bus_a.sel_b), 1);
        cyc();
        inst = r_op(5'd6, 5'd5, 5'd5); settle();
        chk("d1_a_sel_a", 32'(bus_a.sel_a), 2);
        chk("d1_a_sel_b", 32'(bus_a.sel_b), 2);
        chk("d1_b_sel_a", 32'(bus_b.sel_a), 2);
        cyc();
        inst = r_op(5'd7, 5'd5, 5'd5); settle();
        chk("d2_a_sel_a", 32'(bus_a.sel_a), 3);
        chk("d2_b_sel_a", 32'(bus_b.sel_a), 3);
        chk("d2_b_sel_b", 32'(bus_b.sel_b), 3);
        cyc();
        inst = r_op(5'd8, 5'd5, 5'd5); settle();
        chk("d3_b_sel_a", 32'(bus_b.sel_a), 4);
        chk("d3_a_sel_a", 32'(bus_a.sel_a), 0);

        // Youngest wins; rd=x0 never tracked; x0 source never forwarded
        do_reset();
        inst = addi(5'd5, 5'd0); valid = 1'b1; cyc();
        inst = addi(5'd5, 5'd0); cyc();
        inst = r_op(5'd9, 5'd5, 5'd0); settle();
        chk("young_sel_a", 32'(bus_a.sel_a), 2);
        chk("young_sel_b", 32'(bus_a.sel_b), 0);
        inst = addi(5'd0, 5'd5); settle();
        chk("x0w_sel_a", 32'(bus_a.sel_a), 2);
        cyc();
        inst = r_op(5'd11, 5'd0, 5'd5); settle();
        chk("x0src_sel_a", 32'(bus_a.sel_a), 0);
        chk("x0src_sel_b", 32'(bus_a.sel_b), 3);

        // Load-use: LRS=1 never stalls, LRS=2 stalls one cycle
        do_reset();
        inst = lw(5'd7, 5'd1); valid = 1'b1; settle();
        chk("lw_b_stall", 32'(bus_b.stall_req), 0);
        cyc();
        inst = beq(5'd7, 5'd0); settle();
        chk("lu_a_stall", 32'(bus_a.stall_req), 0);
        chk("lu_a_sel_a", 32'(bus_a.sel_a), 2);
        chk("lu_a_sel_b", 32'(bus_a.sel_b), 0);
        chk("lu_b_stall", 32'(bus_b.stall_req), 1);
        cyc();
        settle();
        chk("lu2_b_stall", 32'(bus_b.stall_req), 0);
        chk("lu2_b_cnt",   bus_b.stall_cnt, 1);
        chk("lu2_b_sel_a", 32'(bus_b.sel_a), 3);
        chk("lu2_a_sel_a", 32'(bus_a.sel_a), 3);
        chk("lu2_a_cnt",   bus_a.stall_cnt, 0);

        // Freeze during stall holds slots and counter
        do_reset();
        inst = lw(5'd7, 5'd1); valid = 1'b1; cyc();
        inst = beq(5'd7, 5'd0); freeze = 1'b1;
        cyc(); cyc(); cyc();
        settle();
        chk("frz_b_stall", 32'(bus_b.stall_req), 1);
        chk("frz_b_cnt",   bus_b.stall_cnt, 0);
        chk("frz_a_sel_a", 32'(bus_a.sel_a), 2);
        freeze = 1'b0; cyc(); settle();
        chk("unfrz_b_cnt",   bus_b.stall_cnt, 1);
        chk("unfrz_b_stall", 32'(bus_b.stall_req), 0);
        chk("unfrz_b_sel_a", 32'(bus_b.sel_a), 3);

        // Flush and invalid X insert bubbles; invalid X never stalls
        do_reset();
        inst = addi(5'd5, 5'd0); valid = 1'b1; flush = 1'b1; cyc();
        flush = 1'b0;
        inst = r_op(5'd6, 5'd5, 5'd5); settle();
        chk("flush_sel_a", 32'(bus_a.sel_a), 0);
        valid = 1'b0; inst = addi(5'd5, 5'd0); cyc();
        valid = 1'b1; inst = r_op(5'd6, 5'd5, 5'd5); settle();
        chk("inval_sel_a", 32'(bus_a.sel_a), 0);
        inst = lw(5'd7, 5'd1); cyc();
        valid = 1'b0; inst = beq(5'd7, 5'd0); settle();
        chk("inval_stall", 32'(bus_b.stall_req), 0);

        // Store data forwarding
        do_reset();
        inst = addi(5'd8, 5'd0); valid = 1'b1; cyc();
        inst = sw(5'd8, 5'd9); settle();
        chk("st_sel_b",  32'(bus_a.sel_b), 1);
        chk("st_sel_sd", 32'(bus_a.sel_sd), 2);
        chk("st_sel_a",  32'(bus_a.sel_a), 0);

        // Reset mid-stall
        do_reset();
        inst = lw(5'd7, 5'd1); valid = 1'b1; cyc();
        inst = beq(5'd7, 5'd0); settle();
        chk("prerst_stall", 32'(bus_b.stall_req), 1);
        rst = 1'b1; freeze = 1'b1; cyc(); rst = 1'b0; freeze = 1'b0; settle();
        chk("midrst_stall", 32'(bus_b.stall_req), 0);
        chk("midrst_cnt",   bus_b.stall_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_fwd_unit.md
OPERAND_FWD_UNIT -- requirements
Module: operand_fwd_unit

Interface
REQ-001 Parameter XLEN, default 32, instruction width.
REQ-002 Parameter DEPTH, default 2, number of tracked in-flight stages after X; slot 1 = M, slot DEPTH = oldest.
REQ-003 Parameter LOAD_RDY_STAGE, default 1, lowest slot index whose load data is forwardable; range 1..DEPTH.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 inst_X  in  XLEN  instruction in X.
REQ-008 valid_X  in  1  inst_X is a live instruction.
REQ-009 flush_X  in  1  squash inst_X this cycle.
REQ-010 freeze  in  1  external pipeline hold; slots hold.
REQ-011 sel_a  out  SW=$clog2(DEPTH+2)  A select: 0 REG, 1 PC, 1+k FWD slot k.
REQ-012 sel_b  out  SW  B select: 0 REG, 1 IMM, 1+k FWD slot k.
REQ-013 sel_sd  out  SW  store-data select: 0 REG, 1+k FWD slot k.
REQ-014 stall_req  out  1  load-use hazard; hold X, insert bubble.
REQ-015 stall_cnt  out  32  saturating count of stall_req cycles.

Function
REQ-016 Each slot SHALL hold {valid, rd[4:0], is_load}; slot contents registered, selects combinational from inst_X and slots.
REQ-017 inst_X SHALL be a writer if opcode in {ARI_RTYPE, ARI_ITYPE, LOAD, JAL, JALR, AUIPC, LUI} and rd != x0.
REQ-018 rs1 SHALL be used for RTYPE, ITYPE, LOAD, STORE, BRANCH, JALR; rs2 for RTYPE, STORE, BRANCH.
REQ-019 A source SHALL match slot k when slot valid, source used, source != x0, rd == source.
REQ-020 On multiple matches the lowest k (youngest) SHALL win.
REQ-021 sel_a SHALL be 1 for AUIPC/JAL, else FWD of winning match, else 0.
REQ-022 sel_b SHALL be 1 for ITYPE, LOAD, STORE, JALR, AUIPC, LUI, JAL; else FWD of rs2 winning match, else 0.
REQ-023 sel_sd SHALL apply rs2 matching for STORE only; 0 for all other opcodes.
REQ-024 BRANCH SHALL forward both operands via sel_a/sel_b like RTYPE.
REQ-025 stall_req SHALL be 1 when valid_X, not flush_X, and any used source's winning match is a load in slot k < LOAD_RDY_STAGE; selects are don't-care while stall_req.
REQ-026 With LOAD_RDY_STAGE=1, stall_req SHALL never assert.
REQ-027 Each clock with freeze=0: slot k+1 <= slot k; slot 1 <= inst_X decode if valid_X & writer & ~flush_X & ~stall_req, else invalid (bubble).
REQ-028 freeze=1 SHALL hold all slots and stall_cnt; freeze has priority over stall and flush.
REQ-029 stall_cnt SHALL increment by 1 per cycle with stall_req=1 and freeze=0, saturating at 0xFFFFFFFF.
REQ-030 Hazard resolution: after stall_req, the load advances one slot per cycle; stall_req drops the first cycle the load reaches slot LOAD_RDY_STAGE.
REQ-031 valid_X=0 SHALL force stall_req=0 and insert a bubble.

Reset
REQ-032 rst=1 at a clock edge SHALL clear all slot valid bits and stall_cnt to 0, overriding freeze.
REQ-033 During and after reset with empty slots, stall_req=0, sel_sd=0, sel_a/sel_b per opcode only (0/1).
REQ-034 Reset mid-stall SHALL drop stall_req the next cycle.

Structure
REQ-035 Sel encodings and opcode constants SHALL live in the shared package beside existing opcode/control-select definitions.
REQ-036 One sub-module fwd_match SHALL compute priority winner index and is_load for one source across DEPTH slots; instantiated three times (rs1, rs2 for B, rs2 for store data).

Verification
REQ-037 Reset, then RTYPE x3=x1+x2 with empty slots -> sel_a=0, sel_b=0, stall_req=0, stall_cnt=0.
REQ-038 ADDI x5 then RTYPE x6=x5+x5 next cycle -> sel_a=2, sel_b=2; with DEPTH=3, two cycles later -> sel_a=3, sel_b=3.
REQ-039 Writes to x5 in slots 1 and 2, X reads x5 -> sel_a=2 (youngest wins); rd=x0 writer -> no forward.
REQ-040 LOAD_RDY_STAGE=2: LW x7 then BEQ x7,x0 -> stall_req=1 one cycle, stall_cnt=1, slot 1 bubble; next cycle sel_a=3.
REQ-041 SW x8,0(x9) after ADDI x8 -> sel_b=1, sel_sd=2, sel_a=0.
REQ-042 freeze=1 for 3 cycles during stall -> slots and stall_cnt unchanged; flush_X with writer in X -> slot 1 invalid next cycle.
